// File: rtl/combo_vector_sweeper.sv
// rtl/combo_vector_sweeper.sv - clocked 16-vector sweep and truth-table check for a 4-input combo block
module combo_vector_sweeper #(
    parameter int unsigned DWELL  = 10,
    parameter logic [15:0] EXP_TT = 16'h0000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       o,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_cnt,
    output logic       err_valid,
    output logic [3:0] first_err_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

    localparam logic [7:0] CNT_LAST = 8'(DWELL - 1);

    state_e     state_q, state_d;
    logic [3:0] idx_q, idx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] err_cnt_q, err_cnt_d;
    logic       err_valid_q, err_valid_d;
    logic [3:0] first_q, first_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= 4'd0;
            cnt_q       <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= 5'd0;
            err_valid_q <= 1'b0;
            first_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_cnt_q   <= err_cnt_d;
            err_valid_q <= err_valid_d;
            first_q     <= first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_cnt_d   = err_cnt_q;
        err_valid_d = err_valid_q;
        first_d     = first_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_RUN;
                    idx_d       = 4'd0;
                    cnt_d       = 8'd0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_cnt_d   = 5'd0;
                    err_valid_d = 1'b0;
                    first_d     = 4'd0;
                end
            end
            S_RUN: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d = cnt_q + 8'd1;
                end else begin
                    // Last dwell cycle: o has had DWELL-1 clocks to settle.
                    if (o != EXP_TT[idx_q]) begin
                        err_cnt_d = err_cnt_q + 5'd1;
                        if (!err_valid_q) begin
                            first_d     = idx_q;
                            err_valid_d = 1'b1;
                        end
                    end
                    cnt_d = 8'd0;
                    if (idx_q != 4'hF) begin
                        idx_d = idx_q + 4'd1;
                    end else begin
                        state_d = S_FIN;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_cnt_d == 5'd0);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
                idx_d   = 4'd0;
                cnt_d   = 8'd0;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign a             = idx_q[0];
    assign b             = idx_q[1];
    assign c             = idx_q[2];
    assign d             = idx_q[3];
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_cnt       = err_cnt_q;
    assign err_valid     = err_valid_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_combo_vector_sweeper.sv
// tb/tb_combo_vector_sweeper.sv - directed and randomized checks of the vector sweeper against a truth-table model
module tb_combo_vector_sweeper;

    logic clk = 1'b0;
    logic rst_n;
    logic start0, start1;
    logic [15:0] mask0, mask1;
    logic [15:0] tt0, tt1;

    logic a0, b0, c0, d0, o0, busy0, done0, pass0, ev0;
    logic [4:0] ec0;
    logic [3:0] fi0;
    logic a1, b1, c1, d1, o1, busy1, done1, pass1, ev1;
    logic [4:0] ec1;
    logic [3:0] fi1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Bench combo model: the intended truth table with a per-vector fault mask.
    assign o0 = tt0[{d0, c0, b0, a0}] ^ mask0[{d0, c0, b0, a0}];
    assign o1 = tt1[{d1, c1, b1, a1}] ^ mask1[{d1, c1, b1, a1}];

    combo_vector_sweeper #(.DWELL(10), .EXP_TT(16'hA5C3)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a(a0), .b(b0), .c(c0), .d(d0), .o(o0),
        .busy(busy0), .done(done0), .pass(pass0),
        .err_cnt(ec0), .err_valid(ev0), .first_err_idx(fi0)
    );

    combo_vector_sweeper #(.DWELL(2), .EXP_TT(16'h0000)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a(a1), .b(b1), .c(c1), .d(d1), .o(o1),
        .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(ec1), .err_valid(ev1), .first_err_idx(fi1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] vec(input int w);
        return (w != 0) ? {d1, c1, b1, a1} : {d0, c0, b0, a0};
    endfunction

    function automatic logic sig_busy(input int w);
        return (w != 0) ? busy1 : busy0;
    endfunction

    function automatic logic sig_done(input int w);
        return (w != 0) ? done1 : done0;
    endfunction

    task automatic set_start(input int w, input logic v);
        if (w != 0) start1 = v;
        else start0 = v;
    endtask

    task automatic check_results(input int w, input logic [15:0] tt, input logic [15:0] mask,
                                 input string tag);
        int exp_cnt = 0;
        int exp_first = 0;
        logic seen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if ((tt[i] ^ mask[i]) != tt[i]) begin
                exp_cnt++;
                if (!seen) begin
                    exp_first = i;
                    seen = 1'b1;
                end
            end
        end
        chk({tag, ".err_cnt"},   (w != 0) ? int'(ec1)  : int'(ec0),  exp_cnt);
        chk({tag, ".err_valid"}, (w != 0) ? int'(ev1)  : int'(ev0),  int'(seen));
        chk({tag, ".first_err"}, (w != 0) ? int'(fi1)  : int'(fi0),  exp_first);
        chk({tag, ".pass"},      (w != 0) ? int'(pass1) : int'(pass0), (exp_cnt == 0) ? 1 : 0);
    endtask

    // One complete sweep; optionally pokes start at negedge 'poke' while busy.
    task automatic sweep(input int w, input logic [15:0] mask, input int poke, input string tag);
        int dw = (w != 0) ? 2 : 10;
        int bn = 0;
        int dn = 0;
        int dpos = -1;
        int vbad = 0;
        if (w != 0) mask1 = mask;
        else mask0 = mask;
        @(negedge clk);
        set_start(w, 1'b1);
        @(negedge clk);
        set_start(w, 1'b0);
        for (int k = 0; k < 16 * dw + 4; k++) begin
            if (poke >= 0 && k == poke) set_start(w, 1'b1);
            if (poke >= 0 && k == poke + 1) set_start(w, 1'b0);
            if (sig_busy(w)) begin
                if (int'(vec(w)) != bn / dw) vbad++;
                bn++;
            end
            if (sig_done(w)) begin
                dn++;
                dpos = k;
            end
            @(negedge clk);
        end
        chk({tag, ".busy_cycles"}, bn, 16 * dw);
        chk({tag, ".done_count"}, dn, 1);
        chk({tag, ".done_pos"}, dpos, 16 * dw);
        chk({tag, ".vector_seq_errs"}, vbad, 0);
        chk({tag, ".vec_after"}, int'(vec(w)), 0);
        check_results(w, (w != 0) ? tt1 : tt0, mask, tag);
    endtask

    initial begin
        int dn;
        int dpos[$];
        logic [15:0] m;
        logic got;

        tt0 = 16'hA5C3;
        tt1 = 16'h0000;
        mask0 = 16'h0000;
        mask1 = 16'h0000;
        start0 = 1'b0;
        start1 = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst.vec0", int'({d0, c0, b0, a0}), 0);
        chk("rst.busy0", int'(busy0), 0);
        chk("rst.done0", int'(done0), 0);
        chk("rst.pass0", int'(pass0), 0);
        chk("rst.err_cnt0", int'(ec0), 0);
        chk("rst.err_valid0", int'(ev0), 0);
        chk("rst.first0", int'(fi0), 0);
        chk("rst.vec1", int'({d1, c1, b1, a1}), 0);
        chk("rst.busy1", int'(busy1), 0);
        rst_n = 1'b1;
        @(negedge clk);

        sweep(0, 16'h0000, -1, "clean10");
        sweep(0, 16'h1020, -1, "inv5_12");
        sweep(1, 16'hFFFF, -1, "stuck1");
        sweep(1, 16'h0000, -1, "clean2");
        sweep(1, 16'h1020, -1, "inv5_12_dw2");
        sweep(0, 16'h0000, 31, "poke_idx3");

        for (int r = 0; r < 3; r++) begin
            m = 16'($urandom());
            sweep(0, m, -1, $sformatf("rand%0d_dw10", r));
            sweep(1, m, -1, $sformatf("rand%0d_dw2", r));
        end

        // Asynchronous reset mid-sweep at idx 7.
        mask0 = 16'h0008;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            if ({d0, c0, b0, a0} == 4'd7) got = 1'b1;
            else @(negedge clk);
        end
        chk("midrst.reached_idx7", int'(got), 1);
        chk("midrst.err_before", int'(ec0), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.vec", int'({d0, c0, b0, a0}), 0);
        chk("midrst.busy", int'(busy0), 0);
        chk("midrst.err_cnt", int'(ec0), 0);
        chk("midrst.err_valid", int'(ev0), 0);
        chk("midrst.first", int'(fi0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 200; k++) begin
            if (done0) dn++;
            @(negedge clk);
        end
        chk("midrst.no_done", dn, 0);
        sweep(0, 16'h0000, -1, "after_rst");

        // start held high: back-to-back sweeps every 16*DWELL+2 cycles.
        mask0 = 16'h0000;
        start0 = 1'b1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done0) dpos.push_back(k);
        end
        start0 = 1'b0;
        chk("held.done_count", dpos.size(), 2);
        if (dpos.size() >= 2) chk("held.done_spacing", dpos[1] - dpos[0], 162);
        got = 1'b0;
        for (int k = 0; k < 400 && !got; k++) begin
            @(negedge clk);
            if (done0) got = 1'b1;
        end
        chk("held.drain_done", int'(got), 1);
        @(negedge clk);
        chk("held.drain_busy", int'(busy0), 0);
        chk("held.pass", int'(pass0), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/combo_vector_sweeper.md
Name: combo_vector_sweeper

Overview:
- Upstream stimulus-and-check stage for the 4-input combinational `combo` block.
- Sweeps all 16 input vectors on a, b, c, d in ascending order. Each vector is held for a programmable number of clocks, then the `combo` output o is sampled and compared against an expected truth table.
- Reports mismatch count, first failing vector, and pass/fail.
- Replaces hand-written delay stimulus with a clocked, self-checking sequencer usable on-board as well as in simulation.

Parameters:
- DWELL, 10, clocks each vector is held; legal range 2..255.
- EXP_TT, 16'h0000, expected truth table; bit i is the expected o for vector index i = {d,c,b,a}.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- a  out  1  vector bit 0 to `combo`.
- b  out  1  vector bit 1.
- c  out  1  vector bit 2.
- d  out  1  vector bit 3.
- o  in  1  `combo` output; same clock domain, combinational from a..d.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse after the last sample.
- pass  out  1  high when the completed sweep had zero mismatches.
- err_cnt  out  5  mismatches in the last/current sweep, 0..16.
- err_valid  out  1  at least one mismatch recorded.
- first_err_idx  out  4  index of the first mismatching vector.

Behaviour:
- Reset (rst_n low, asynchronous, any state) forces:
  - FSM to IDLE.
  - a, b, c, d, busy, done, pass, err_valid = 0; err_cnt = 0; first_err_idx = 0.
  - Internal idx = 0, dwell counter cnt = 0.
  - Reset mid-sweep aborts the sweep; no done pulse.
- Outputs a..d are registered and always equal idx bits: a=idx[0], b=idx[1], c=idx[2], d=idx[3].
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - start=1 at an edge → RUN. On that edge: idx=0, cnt=0, busy=1, err_cnt=0, err_valid=0, pass=0, first_err_idx=0.
  - start=0 → stay; pass, err_cnt, err_valid and first_err_idx hold their last values.
- RUN:
  - Each edge with cnt<DWELL-1 → cnt+1.
  - On the edge with cnt==DWELL-1, o is sampled and compared with EXP_TT[idx]. Mismatch → err_cnt+1; if err_valid was 0, first_err_idx=idx and err_valid=1.
  - Same edge, idx<15 → idx+1, cnt=0 (vector changes).
  - Same edge, idx==15 → FIN; a..d hold 4'hF.
- FIN (one cycle): done=1, busy=0, pass=(err_cnt==0). Next edge → IDLE with done=0 and a..d returned to 0.
- Latency: busy is high for exactly 16*DWELL cycles. done is asserted on the cycle after the 16th sample.
- The sample point is the last dwell cycle, giving o DWELL-1 clocks to settle after a vector change.
- start while busy or in FIN is ignored. start held high continuously re-triggers from IDLE, giving back-to-back sweeps separated by 2 cycles (FIN + IDLE).
- err_cnt is 5 bits so 16 mismatches fit; no saturation logic is needed.
- The mismatch update and the final-sample FIN transition share one edge; the final sample's mismatch is included in pass.
- Width rule: cnt is 8 bits, compared against DWELL-1.

Test Plan:
- Reset, then a 1-cycle start pulse with the bench `combo` model matching EXP_TT=16'hA5C3 → a..d step 0..15 every 10 clocks; busy high for 160 clocks; done pulses once; pass=1, err_cnt=0, err_valid=0.
- Model forces o inverted on idx 5 and 12 only → err_cnt=2, first_err_idx=5, err_valid=1, pass=0.
- Model output stuck at 1 with EXP_TT=16'h0000 → err_cnt=16 (5'b10000), first_err_idx=0, pass=0.
- rst_n pulled low at idx=7 mid-sweep → all outputs 0 immediately (asynchronous); no done pulse; a later start runs a full clean sweep from idx 0.
- start pulsed at idx 3 during busy → ignored; sweep completes normally with a single done pulse. start held high for 400 cycles → two full sweeps, done pulses 162 cycles apart.
- DWELL=2 build → vector changes every 2 clocks; busy is 32 clocks; results match the DWELL=10 run.
